// File: rtl/mem_agu_pkg.sv
// Shared opcode constants for the memory address generation unit.
// Only the memory-format opcodes the AGU decodes are listed here.
package mem_agu_pkg;
  localparam int OPC_W = 6;

  localparam logic [OPC_W-1:0] LDA   = 6'h08;
  localparam logic [OPC_W-1:0] LDAH  = 6'h09;
  localparam logic [OPC_W-1:0] LDQ_U = 6'h0B;
  localparam logic [OPC_W-1:0] STQ_U = 6'h0F;
  localparam logic [OPC_W-1:0] LDL   = 6'h28;
  localparam logic [OPC_W-1:0] LDQ   = 6'h29;
  localparam logic [OPC_W-1:0] STL   = 6'h2C;
  localparam logic [OPC_W-1:0] STQ   = 6'h2D;
endpackage

// File: rtl/mem_agu_fifo.sv
// Result queue for the AGU: DEPTH entries of PW bits, in-order.
// in_ready depends only on occupancy, never on out_ready.
module agu_fifo #(
  parameter int PW    = 8,
  parameter int DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [PW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [PW-1:0] out_data
);
  localparam int PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNTW = $clog2(DEPTH + 1);
  localparam logic [PTRW-1:0] LAST = PTRW'(DEPTH - 1);
  localparam logic [CNTW-1:0] FULL = CNTW'(DEPTH);

  logic [PW-1:0]   mem [DEPTH];
  logic [PTRW-1:0] wr_ptr;
  logic [PTRW-1:0] rd_ptr;
  logic [CNTW-1:0] count;
  logic            push;
  logic            pop;

  assign in_ready  = (count < FULL);
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_data  = out_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + PTRW'(1);
      if (pop)
        rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + PTRW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CNTW'(1);
        2'b01:   count <= count - CNTW'(1);
        default: count <= count;
      endcase
    end
  end

  // Payload storage needs no reset; out_data is gated by out_valid.
  always_ff @(posedge clk) begin
    if (push && !rst)
      mem[wr_ptr] <= in_data;
  end
endmodule

// File: rtl/mem_agu.sv
// Memory AGU: combinational address generation in front of agu_fifo.
// Define MEM_AGU_ALIGN_CHK_EN to flag misaligned LDL/STL/LDQ/STQ.
module mem_agu
  import mem_agu_pkg::*;
#(
  parameter int W     = 64,
  parameter int CW    = 16,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OPC_W-1:0] in_opcode,
  input  logic [W-1:0]     in_op1,
  input  logic [W-1:0]     in_op2,
  input  logic [CW-1:0]    in_const,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_res_data,
  output logic [W-1:0]     out_res_adr,
  output logic             out_is_mem,
  output logic             out_exc
);
`ifdef MEM_AGU_ALIGN_CHK_EN
  localparam int PW = 2 * W + 2;
`else
  localparam int PW = 2 * W + 1;
`endif

  logic [W-1:0]  sext;
  logic [W-1:0]  ea;
  logic [W-1:0]  ldah;
  logic          is_l;
  logic          is_q;
  logic          is_u;
  logic [W-1:0]  res_data;
  logic [W-1:0]  res_adr;
  logic          is_mem;
  logic [PW-1:0] in_pl;
  logic [PW-1:0] out_pl;

  assign sext = {{(W-CW){in_const[CW-1]}}, in_const};
  assign ea   = sext + in_op2;
  assign ldah = (sext << 16) + in_op2;
  assign is_l = (in_opcode == LDL) || (in_opcode == STL);
  assign is_q = (in_opcode == LDQ) || (in_opcode == STQ);
  assign is_u = (in_opcode == LDQ_U) || (in_opcode == STQ_U);

  always_comb begin
    res_data = in_op1;
    res_adr  = '0;
    is_mem   = 1'b0;
    unique case (1'b1)
      (in_opcode == LDA):  res_data = ea;
      (in_opcode == LDAH): res_data = ldah;
      (is_l || is_q): begin
        res_adr = ea;
        is_mem  = 1'b1;
      end
      is_u: begin
        res_adr = {ea[W-1:3], 3'b000};
        is_mem  = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef MEM_AGU_ALIGN_CHK_EN
  logic exc;
  assign exc = (is_l && (ea[1:0] != 2'b00))
            || (is_q && (ea[2:0] != 3'b000));
  assign in_pl   = {exc, is_mem, res_adr, res_data};
  assign out_exc = out_pl[2*W+1];
`else
  assign in_pl   = {is_mem, res_adr, res_data};
  assign out_exc = 1'b0;
`endif

  assign out_res_data = out_pl[W-1:0];
  assign out_res_adr  = out_pl[2*W-1:W];
  assign out_is_mem   = out_pl[2*W];

  agu_fifo #(
    .PW    (PW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_pl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_pl)
  );
endmodule

// File: tb/tb_mem_agu.sv
// Directed bench for mem_agu (W=64, DEPTH=2).
// Expected exc values depend on MEM_AGU_ALIGN_CHK_EN.
module tb_mem_agu;
  import mem_agu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  in_opcode;
  logic [63:0] in_op1;
  logic [63:0] in_op2;
  logic [15:0] in_const;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_res_data;
  logic [63:0] out_res_adr;
  logic        out_is_mem;
  logic        out_exc;

  int checks = 0;
  int errors = 0;

`ifdef MEM_AGU_ALIGN_CHK_EN
  localparam logic EXC_ON = 1'b1;
`else
  localparam logic EXC_ON = 1'b0;
`endif

  mem_agu #(.W(64), .CW(16), .DEPTH(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_opcode    (in_opcode),
    .in_op1       (in_op1),
    .in_op2       (in_op2),
    .in_const     (in_const),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_res_data (out_res_data),
    .out_res_adr  (out_res_adr),
    .out_is_mem   (out_is_mem),
    .out_exc      (out_exc)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [5:0] opc, input logic [15:0] c,
                       input logic [63:0] op2, input logic [63:0] op1);
    in_valid  = 1'b1;
    in_opcode = opc;
    in_const  = c;
    in_op2    = op2;
    in_op1    = op1;
  endtask

  task automatic idle_out();
    chk("empty_valid", {63'd0, out_valid}, 64'd0);
    chk("empty_data", out_res_data, 64'd0);
    chk("empty_adr", out_res_adr, 64'd0);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_opcode = '0;
    in_op1    = '0;
    in_op2    = '0;
    in_const  = '0;
    out_ready = 1'b0;
    tick();
    rst = 1'b0;
    chk("rst_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_data", out_res_data, 64'd0);
    chk("rst_adr", out_res_adr, 64'd0);
    chk("rst_mem", {63'd0, out_is_mem}, 64'd0);
    chk("rst_exc", {63'd0, out_exc}, 64'd0);

    out_ready = 1'b1;
    drive(LDA, 16'hFFF0, 64'h100, 64'h5);
    tick();
    in_valid = 1'b0;
    chk("lda_valid", {63'd0, out_valid}, 64'd1);
    chk("lda_data", out_res_data, 64'hF0);
    chk("lda_adr", out_res_adr, 64'd0);
    chk("lda_mem", {63'd0, out_is_mem}, 64'd0);
    tick();
    idle_out();

    drive(LDAH, 16'h0001, 64'h10, 64'h0);
    tick();
    in_valid = 1'b0;
    chk("ldah_data", out_res_data, 64'h10010);
    chk("ldah_adr", out_res_adr, 64'd0);
    tick();

    drive(LDQ_U, 16'h0007, 64'h1000, 64'hAB);
    tick();
    in_valid = 1'b0;
    chk("ldqu_adr", out_res_adr, 64'h1000);
    chk("ldqu_data", out_res_data, 64'hAB);
    chk("ldqu_mem", {63'd0, out_is_mem}, 64'd1);
    tick();

    drive(LDL, 16'h0002, 64'h1000, 64'h55);
    tick();
    in_valid = 1'b0;
    chk("ldl_adr", out_res_adr, 64'h1002);
    chk("ldl_exc", {63'd0, out_exc}, {63'd0, EXC_ON});
    chk("ldl_mem", {63'd0, out_is_mem}, 64'd1);
    tick();

    drive(STQ, 16'h0004, 64'h2000, 64'hBEEF);
    tick();
    in_valid = 1'b0;
    chk("stq_adr", out_res_adr, 64'h2004);
    chk("stq_data", out_res_data, 64'hBEEF);
    chk("stq_exc", {63'd0, out_exc}, {63'd0, EXC_ON});
    tick();

    drive(STL, 16'h0004, 64'h2000, 64'h77);
    tick();
    in_valid = 1'b0;
    chk("stl_al_exc", {63'd0, out_exc}, 64'd0);
    tick();

    drive(LDA, 16'h8000, 64'h0, 64'h0);
    tick();
    in_valid = 1'b0;
    chk("lda_neg", out_res_data, 64'hFFFF_FFFF_FFFF_8000);
    tick();

    drive(6'h10, 16'h0040, 64'h99, 64'h1234);
    tick();
    in_valid = 1'b0;
    chk("oth_data", out_res_data, 64'h1234);
    chk("oth_adr", out_res_adr, 64'd0);
    chk("oth_mem", {63'd0, out_is_mem}, 64'd0);
    tick();

    out_ready = 1'b0;
    drive(LDA, 16'h0001, 64'h0, 64'h0);
    tick();
    drive(LDA, 16'h0002, 64'h0, 64'h0);
    tick();
    in_valid = 1'b0;
    chk("full_ready", {63'd0, in_ready}, 64'd0);
    chk("full_head", out_res_data, 64'd1);
    drive(LDA, 16'h0009, 64'h0, 64'h0);
    tick();
    in_valid = 1'b0;
    chk("full_ign", out_res_data, 64'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_ready", {63'd0, in_ready}, 64'd1);
    chk("bp_head", out_res_data, 64'd2);

    out_ready = 1'b1;
    drive(LDA, 16'h0003, 64'h0, 64'h0);
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("sim_head", out_res_data, 64'd3);
    chk("sim_ready", {63'd0, in_ready}, 64'd1);

    drive(LDA, 16'h0004, 64'h0, 64'h0);
    tick();
    in_valid = 1'b0;
    chk("pre_rst_full", {63'd0, in_ready}, 64'd0);
    rst       = 1'b1;
    out_ready = 1'b1;
    drive(LDA, 16'h0005, 64'h0, 64'h0);
    tick();
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("mrst_ready", {63'd0, in_ready}, 64'd1);
    chk("mrst_mem", {63'd0, out_is_mem}, 64'd0);
    chk("mrst_exc", {63'd0, out_exc}, 64'd0);
    idle_out();

    drive(LDQ, 16'h0008, 64'h3000, 64'h66);
    tick();
    in_valid = 1'b0;
    chk("post_adr", out_res_adr, 64'h3008);
    chk("post_exc", {63'd0, out_exc}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
